inst_sram_axi_bridge: RTL and testbench

//  Instruction-side adapter between the IF stage's SRAM-like fetch port and an AXI3/4 read master.

---
 rtl/inst_sram_axi_bridge.sv | 121 ++++++++++++
 tb/tb_inst_sram_axi_bridge.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_sram_axi_bridge.sv
// Instruction-fetch adapter: SRAM-like fetch port to single-beat AXI reads.
// One AR request in flight on the bus at a time; up to MAX_OUTSTANDING reads awaiting data.
module inst_sram_axi_bridge #(
  parameter int         MAX_OUTSTANDING = 2,
  parameter logic [3:0] AXI_ID          = 4'h0
) (
  input  logic        clk,
  input  logic        reset,
  // SRAM-like fetch port
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  // AXI read address channel
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  // AXI read data channel
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  localparam logic [2:0] MAX_CNT = 3'(MAX_OUTSTANDING);

  typedef enum logic {
    AR_IDLE = 1'b0,
    AR_BUSY = 1'b1
  } ar_state_t;

  ar_state_t   state_reg;
  logic        arvalid_reg;
  logic [31:0] araddr_reg;
  logic [2:0]  arsize_reg;
  logic [2:0]  cnt_reg;
  logic [2:0]  cnt_next;
  logic        accept;
  logic        ret;

  // Fields the read-only fetch path never looks at.
  logic unused_inputs;
  assign unused_inputs = ^{inst_sram_wstrb, inst_sram_wdata, rid, rresp, rlast};

  // A return frees a slot in the same cycle, so a full bridge may accept alongside it.
  assign ret    = rvalid & rready;
  assign accept = ~reset & (state_reg == AR_IDLE) & inst_sram_req & ~inst_sram_wr
                  & ((cnt_reg < MAX_CNT) | ret);

  always_comb begin
    cnt_next = cnt_reg;
    case ({accept, ret})
      2'b10:   cnt_next = cnt_reg + 3'd1;
      2'b01:   cnt_next = cnt_reg - 3'd1;
      default: cnt_next = cnt_reg;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= AR_IDLE;
      arvalid_reg <= 1'b0;
      araddr_reg  <= 32'h0;
      arsize_reg  <= 3'h0;
      cnt_reg     <= 3'h0;
    end else begin
      cnt_reg <= cnt_next;
      case (state_reg)
        AR_IDLE: begin
          if (accept) begin
            araddr_reg  <= inst_sram_addr;
            arsize_reg  <= {1'b0, inst_sram_size};
            arvalid_reg <= 1'b1;
            state_reg   <= AR_BUSY;
          end
        end
        AR_BUSY: begin
          if (arvalid_reg && arready) begin
            arvalid_reg <= 1'b0;
            state_reg   <= AR_IDLE;
          end
        end
        default: begin
          arvalid_reg <= 1'b0;
          state_reg   <= AR_IDLE;
        end
      endcase
    end
  end

  assign inst_sram_addr_ok = accept;
  // Beats arriving with nothing outstanding are left unacknowledged.
  assign rready            = (cnt_reg != 3'd0);
  assign inst_sram_data_ok = ret;
  assign inst_sram_rdata   = rdata;

  assign arid    = AXI_ID;
  assign araddr  = araddr_reg;
  assign arlen   = 8'h0;
  assign arsize  = arsize_reg;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'h0;
  assign arprot  = 3'h0;
  assign arvalid = arvalid_reg;

endmodule

// File: tb/tb_inst_sram_axi_bridge.sv
// Directed bench for inst_sram_axi_bridge: inputs change 1ns after posedge, outputs sampled at negedge.
module tb_inst_sram_axi_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  int n_cmp = 0;
  int n_bad = 0;
  int n_acc;

  always #5 clk = ~clk;

  inst_sram_axi_bridge #(.MAX_OUTSTANDING(2), .AXI_ID(4'h0)) dut (
    .clk               (clk),
    .reset             (reset),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_wr      (inst_sram_wr),
    .inst_sram_size    (inst_sram_size),
    .inst_sram_wstrb   (inst_sram_wstrb),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_wdata   (inst_sram_wdata),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata),
    .arid              (arid),
    .araddr            (araddr),
    .arlen             (arlen),
    .arsize            (arsize),
    .arburst           (arburst),
    .arlock            (arlock),
    .arcache           (arcache),
    .arprot            (arprot),
    .arvalid           (arvalid),
    .arready           (arready),
    .rid               (rid),
    .rdata             (rdata),
    .rresp             (rresp),
    .rlast             (rlast),
    .rvalid            (rvalid),
    .rready            (rready)
  );

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  // Move to 1ns past the next rising edge (input drive point).
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Move to the negedge of the current cycle (sample point).
  task automatic settle();
    #4;
  endtask

  initial begin
    reset = 1'b1;
    inst_sram_req = 1'b0; inst_sram_wr = 1'b0; inst_sram_size = 2'h2;
    inst_sram_wstrb = 4'h0; inst_sram_addr = 32'h0; inst_sram_wdata = 32'h0;
    arready = 1'b0; rid = 4'h0; rdata = 32'h0; rresp = 2'h0; rlast = 1'b1; rvalid = 1'b0;

    // Reset state, including req asserted during reset
    #12;
    inst_sram_req = 1'b1;
    #1;
    chk_eq("rst_arvalid", 32'(arvalid), 0);
    chk_eq("rst_araddr", araddr, 0);
    chk_eq("rst_arsize", 32'(arsize), 0);
    chk_eq("rst_addr_ok", 32'(inst_sram_addr_ok), 0);
    chk_eq("rst_rready", 32'(rready), 0);
    chk_eq("rst_const", {arid, arlen, arburst, arlock, arcache, arprot, 3'b000}, {4'h0, 8'h0, 2'b01, 2'b00, 4'h0, 3'h0, 3'b000});
    inst_sram_req = 1'b0;
    tick();
    reset = 1'b0;

    // 1: single fetch
    tick();
    inst_sram_req = 1'b1; inst_sram_addr = 32'hbfc00000; arready = 1'b1;
    settle();
    chk_eq("t1_addr_ok_T0", 32'(inst_sram_addr_ok), 1);
    chk_eq("t1_arvalid_T0", 32'(arvalid), 0);
    tick();
    inst_sram_req = 1'b0;
    settle();
    chk_eq("t1_arvalid_T1", 32'(arvalid), 1);
    chk_eq("t1_araddr", araddr, 32'hbfc00000);
    chk_eq("t1_arsize", 32'(arsize), 2);
    chk_eq("t1_rready", 32'(rready), 1);
    tick();
    settle();
    chk_eq("t1_arvalid_T2", 32'(arvalid), 0);
    tick();
    tick();
    rvalid = 1'b1; rdata = 32'h3c1d0001;
    settle();
    chk_eq("t1_data_ok", 32'(inst_sram_data_ok), 1);
    chk_eq("t1_rdata", inst_sram_rdata, 32'h3c1d0001);
    tick();
    rvalid = 1'b0;
    settle();
    chk_eq("t1_cnt_end", 32'(dut.cnt_reg), 0);
    chk_eq("t1_rready_end", 32'(rready), 0);

    // Protocol error: rvalid with nothing outstanding
    rvalid = 1'b1; rdata = 32'hdeadbeef;
    #1;
    chk_eq("perr_rready", 32'(rready), 0);
    chk_eq("perr_data_ok", 32'(inst_sram_data_ok), 0);
    tick();
    rvalid = 1'b0;

    // 2: arready low for 4 cycles
    inst_sram_req = 1'b1; inst_sram_addr = 32'h00001000; arready = 1'b0;
    settle();
    chk_eq("t2_addr_ok", 32'(inst_sram_addr_ok), 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 4) arready = 1'b1;
      settle();
      chk_eq($sformatf("t2_arvalid_%0d", i), 32'(arvalid), 1);
      chk_eq($sformatf("t2_araddr_%0d", i), araddr, 32'h00001000);
      chk_eq($sformatf("t2_addr_ok_%0d", i), 32'(inst_sram_addr_ok), 0);
    end
    tick();
    inst_sram_req = 1'b0;
    settle();
    chk_eq("t2_arvalid_done", 32'(arvalid), 0);
    tick();
    rvalid = 1'b1; rdata = 32'h11112222;
    settle();
    chk_eq("t2_data_ok", 32'(inst_sram_data_ok), 1);
    tick();
    rvalid = 1'b0;

    // 3: fill to MAX_OUTSTANDING=2, then return + accept in the same cycle
    n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      inst_sram_req = 1'b1; inst_sram_addr = 32'h3000 + 32'(i * 4);
      settle();
      if (inst_sram_addr_ok) n_acc++;
      tick();
    end
    chk_eq("t3_accepts", 32'(n_acc), 2);
    chk_eq("t3_cnt_full", 32'(dut.cnt_reg), 2);
    rvalid = 1'b1; rdata = 32'haaaa0001;
    settle();
    chk_eq("t3_data_ok", 32'(inst_sram_data_ok), 1);
    chk_eq("t3_addr_ok_same", 32'(inst_sram_addr_ok), 1);
    tick();
    rvalid = 1'b0; inst_sram_req = 1'b0;
    settle();
    chk_eq("t3_cnt_hold", 32'(dut.cnt_reg), 2);
    chk_eq("t3_arvalid", 32'(arvalid), 1);
    tick();
    rvalid = 1'b1;
    settle();
    chk_eq("t3_drain1", 32'(inst_sram_data_ok), 1);
    tick();
    settle();
    chk_eq("t3_drain2", 32'(inst_sram_data_ok), 1);
    tick();
    rvalid = 1'b0;
    settle();
    chk_eq("t3_cnt_end", 32'(dut.cnt_reg), 0);

    // 4: accept and return together at cnt=1
    tick();
    inst_sram_req = 1'b1; inst_sram_addr = 32'h4000;
    settle();
    chk_eq("t4_addr_ok_a", 32'(inst_sram_addr_ok), 1);
    tick();
    inst_sram_req = 1'b0;
    tick();
    inst_sram_req = 1'b1; inst_sram_addr = 32'h4004; rvalid = 1'b1; rdata = 32'h44440001;
    settle();
    chk_eq("t4_cnt_before", 32'(dut.cnt_reg), 1);
    chk_eq("t4_addr_ok_b", 32'(inst_sram_addr_ok), 1);
    chk_eq("t4_data_ok_b", 32'(inst_sram_data_ok), 1);
    tick();
    inst_sram_req = 1'b0; rvalid = 1'b0;
    settle();
    chk_eq("t4_cnt_after", 32'(dut.cnt_reg), 1);
    chk_eq("t4_araddr", araddr, 32'h4004);
    tick();
    rvalid = 1'b1; rdata = 32'h44440002;
    settle();
    chk_eq("t4_rdata", inst_sram_rdata, 32'h44440002);
    tick();
    rvalid = 1'b0;
    settle();
    chk_eq("t4_cnt_end", 32'(dut.cnt_reg), 0);

    // 5: write requests are never accepted
    for (int i = 0; i < 4; i++) begin
      tick();
      inst_sram_req = 1'b1; inst_sram_wr = 1'b1; inst_sram_addr = 32'h5000;
      settle();
      chk_eq($sformatf("t5_addr_ok_%0d", i), 32'(inst_sram_addr_ok), 0);
      chk_eq($sformatf("t5_arvalid_%0d", i), 32'(arvalid), 0);
    end
    tick();
    inst_sram_req = 1'b0; inst_sram_wr = 1'b0;

    // 6: asynchronous reset while in AR_BUSY
    arready = 1'b0;
    inst_sram_req = 1'b1; inst_sram_addr = 32'h6000;
    tick();
    inst_sram_req = 1'b0;
    settle();
    chk_eq("t6_busy_arvalid", 32'(arvalid), 1);
    #2;
    reset = 1'b1;
    #1;
    chk_eq("t6_rst_arvalid", 32'(arvalid), 0);
    chk_eq("t6_rst_cnt", 32'(dut.cnt_reg), 0);
    chk_eq("t6_rst_rready", 32'(rready), 0);
    #3;
    reset = 1'b0;
    tick();
    inst_sram_req = 1'b1; inst_sram_addr = 32'h2000; arready = 1'b1;
    settle();
    chk_eq("t6_addr_ok", 32'(inst_sram_addr_ok), 1);
    tick();
    inst_sram_req = 1'b0;
    settle();
    chk_eq("t6_arvalid", 32'(arvalid), 1);
    chk_eq("t6_araddr", araddr, 32'h2000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
